// File: rtl/test_pattern_sequencer_if.sv
// CPU register bus for the test pattern sequencer: select, write strobe,
// 2-bit address, write data and registered read data.
interface test_pattern_sequencer_if;
  logic       cs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (output cs, output we, output addr, output wdata, input rdata);
  modport slave  (input cs, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/test_pattern_sequencer.sv
// Frame-synchronous test pattern sequencer: manual, auto-cycle and one-shot
// sweep of the DVI generator's pattern select, configured over a 4-register bus.
module test_pattern_sequencer #(
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int DEFAULT_DWELL = 60
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [9:0]                h_count,
  input  logic [9:0]                v_count,
  test_pattern_sequencer_if.slave   bus,
  output logic [1:0]                pattern_sel,
  output logic                      pattern_active,
  output logic                      frame_tick
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MANUAL  = 2'd1,
    ST_AUTO    = 2'd2,
    ST_ONESHOT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  ctrl_q, ctrl_d;
  logic [7:0]  dwell_q, dwell_d;
  logic [3:0]  mask_q, mask_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  sel_q, sel_d;
  logic        active_q, active_d;
  logic        done_q, done_d;
  logic        restart_q, restart_d;
  logic        tick_q, tick_d;
  logic [7:0]  rdata_q, rdata_d;

  logic        wr_s;
  logic        rd_s;
  logic        ctrl_en_s;
  logic [1:0]  ctrl_mode_s;
  logic [1:0]  ctrl_msel_s;
  logic [7:0]  dwell_lim_s;
  logic [2:0]  next_s;
  logic [7:0]  status_s;

  // Nearest enabled pattern above cur; bit 2 of the result flags a hit.
  function automatic logic [2:0] find_next(input logic [1:0] cur, input logic [3:0] mask,
                                           input logic wrap);
    logic [2:0] res;
    logic [2:0] cand;
    res = 3'b000;
    for (int k = 3; k >= 1; k--) begin
      cand = {1'b0, cur} + 3'(k);
      if (mask[cand[1:0]] && (wrap || !cand[2])) begin
        res = {1'b1, cand[1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [1:0] lowest_bit(input logic [3:0] mask);
    logic [1:0] res;
    res = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (mask[k]) begin
        res = 2'(k);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign wr_s        = bus.cs & bus.we;
  assign rd_s        = bus.cs & ~bus.we;
  assign ctrl_en_s   = ctrl_q[0];
  assign ctrl_mode_s = ctrl_q[2:1];
  assign ctrl_msel_s = ctrl_q[4:3];
  assign dwell_lim_s = (dwell_q == 8'd0) ? 8'd1 : dwell_q;
  assign next_s      = find_next(sel_q, mask_q, state_q == ST_AUTO);
  assign status_s    = {2'b00, state_q, done_q, active_q, sel_q};

  // Frame boundary is the first visible column of the first blanking line.
  assign tick_d = (h_count == 10'd0) && (h_count < 10'(H_ACTIVE)) &&
                  (v_count == 10'(V_ACTIVE));

  // Registered read mux; holds when not reading.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_s) begin
      case (bus.addr)
        2'd0:    rdata_d = {3'b000, ctrl_q};
        2'd1:    rdata_d = dwell_q;
        2'd2:    rdata_d = {4'b0000, mask_q};
        default: rdata_d = status_s;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Sequencer next state on frame ticks, then register writes (a CTRL write wins restart).
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    dwell_d   = dwell_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    active_d  = active_q;
    done_d    = done_q;
    restart_d = restart_q;

    if (tick_q) begin
      if (restart_q || (state_q == ST_IDLE)) begin
        restart_d = 1'b0;
        done_d    = 1'b0;
        cnt_d     = 8'd0;
        if (!ctrl_en_s) begin
          state_d  = ST_IDLE;
          active_d = 1'b0;
        end else begin
          active_d = 1'b1;
          case (ctrl_mode_s)
            2'b01: begin
              state_d = ST_AUTO;
              sel_d   = (mask_q == 4'd0) ? ctrl_msel_s : lowest_bit(mask_q);
            end
            2'b10: begin
              state_d = ST_ONESHOT;
              sel_d   = (mask_q == 4'd0) ? ctrl_msel_s : lowest_bit(mask_q);
            end
            default: begin
              state_d = ST_MANUAL;
              sel_d   = ctrl_msel_s;
            end
          endcase
        end
      end else if (((state_q == ST_AUTO) || (state_q == ST_ONESHOT)) && !done_q) begin
        if (cnt_q == (dwell_lim_s - 8'd1)) begin
          cnt_d = 8'd0;
          if (next_s[2]) begin
            sel_d = next_s[1:0];
          end else if ((state_q == ST_ONESHOT) && (mask_q != 4'd0)) begin
            active_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            sel_d = sel_q;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end else begin
        sel_d = sel_q;
      end
    end else begin
      state_d = state_q;
    end

    if (wr_s) begin
      case (bus.addr)
        2'd0: begin
          ctrl_d    = bus.wdata[4:0];
          restart_d = 1'b1;
        end
        2'd1:    dwell_d = bus.wdata;
        2'd2:    mask_d  = bus.wdata[3:0];
        default: ctrl_d  = ctrl_q;
      endcase
    end else begin
      ctrl_d = ctrl_d;
    end
  end

  // State and register flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= 5'd0;
      dwell_q   <= 8'(DEFAULT_DWELL);
      mask_q    <= 4'hF;
      cnt_q     <= 8'd0;
      sel_q     <= 2'd0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      restart_q <= 1'b0;
      tick_q    <= 1'b0;
      rdata_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      dwell_q   <= dwell_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      active_q  <= active_d;
      done_q    <= done_d;
      restart_q <= restart_d;
      tick_q    <= tick_d;
      rdata_q   <= rdata_d;
    end
  end

  assign pattern_sel    = sel_q;
  assign pattern_active = active_q;
  assign frame_tick     = tick_q;
  assign bus.rdata      = rdata_q;

endmodule

// File: tb/tb_test_pattern_sequencer.sv
// Bench for test_pattern_sequencer: directed vector table, hand-written corner
// sequences, then random traffic against a behavioural model.
module tb_test_pattern_sequencer;

  logic       clk;
  logic       rst;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic [1:0] pattern_sel;
  logic       pattern_active;
  logic       frame_tick;

  test_pattern_sequencer_if bus_if();

  test_pattern_sequencer #(.H_ACTIVE(640), .V_ACTIVE(480), .DEFAULT_DWELL(60)) dut (
    .clk            (clk),
    .rst            (rst),
    .h_count        (h_count),
    .v_count        (v_count),
    .bus            (bus_if),
    .pattern_sel    (pattern_sel),
    .pattern_active (pattern_active),
    .frame_tick     (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: config registers plus observable sequencer status.
  int m_ctrl, m_dwell, m_mask, m_restart, m_st, m_sel, m_act, m_done, m_cnt, m_tick, m_rd;

  typedef struct {
    int op;    // 0 write, 1 read, 2 full frame
    int addr;
    int data;
    int esel;
    int eact;
    int erd;   // -1: rdata not checked
  } vec_t;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 0; m_dwell = 60; m_mask = 15; m_restart = 0; m_st = 0;
    m_sel = 0; m_act = 0; m_done = 0; m_cnt = 0; m_tick = 0; m_rd = 0;
  endtask

  function automatic int lowest_enabled(input int mask);
    for (int i = 0; i < 4; i++) if (((mask >> i) & 1) != 0) return i;
    return 0;
  endfunction

  // Next pattern in the enabled list after cur; -1 means stay / nothing further.
  function automatic int next_enabled(input int cur, input int mask, input bit wrap);
    int lst[$];
    for (int i = 0; i < 4; i++) if (((mask >> i) & 1) != 0) lst.push_back(i);
    foreach (lst[i]) if (lst[i] > cur) return lst[i];
    if (wrap && lst.size() > 0 && lst[0] != cur) return lst[0];
    return -1;
  endfunction

  task automatic model_step();
    int en, mode, ms, lim, nx, status;
    bit new_tick;
    if (rst) begin
      model_reset();
      return;
    end
    new_tick = (h_count == 10'd0) && (v_count == 10'd480);
    status = m_sel | (m_act << 2) | (m_done << 3) | (m_st << 4);
    if (bus_if.cs && !bus_if.we) begin
      case (bus_if.addr)
        2'd0:    m_rd = m_ctrl;
        2'd1:    m_rd = m_dwell;
        2'd2:    m_rd = m_mask;
        default: m_rd = status;
      endcase
    end
    if (m_tick != 0) begin
      if (m_restart != 0 || m_st == 0) begin
        m_restart = 0; m_done = 0; m_cnt = 0;
        en = m_ctrl & 1; mode = (m_ctrl >> 1) & 3; ms = (m_ctrl >> 3) & 3;
        if (en == 0) begin
          m_st = 0; m_act = 0;
        end else begin
          m_act = 1;
          if (mode == 1 || mode == 2) begin
            m_st  = mode + 1;
            m_sel = (m_mask == 0) ? ms : lowest_enabled(m_mask);
          end else begin
            m_st = 1; m_sel = ms;
          end
        end
      end else if ((m_st == 2 || m_st == 3) && m_done == 0) begin
        lim = (m_dwell == 0) ? 1 : m_dwell;
        if (m_cnt == lim - 1) begin
          m_cnt = 0;
          nx = next_enabled(m_sel, m_mask, m_st == 2);
          if (nx >= 0) m_sel = nx;
          else if (m_st == 3 && m_mask != 0) begin
            m_act = 0; m_done = 1;
          end
        end else begin
          m_cnt = (m_cnt + 1) % 256;
        end
      end
    end
    if (bus_if.cs && bus_if.we) begin
      case (bus_if.addr)
        2'd0: begin m_ctrl = bus_if.wdata & 31; m_restart = 1; end
        2'd1: m_dwell = bus_if.wdata;
        2'd2: m_mask = bus_if.wdata & 15;
        default: ;
      endcase
    end
    m_tick = new_tick ? 1 : 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_op(input int op, input int addr, input int data);
    case (op)
      0: begin
        bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.addr = 2'(addr); bus_if.wdata = 8'(data);
        cyc();
        bus_if.cs = 1'b0; bus_if.we = 1'b0;
      end
      1: begin
        bus_if.cs = 1'b1; bus_if.we = 1'b0; bus_if.addr = 2'(addr);
        cyc();
        bus_if.cs = 1'b0;
      end
      default: begin
        h_count = 10'd0; v_count = 10'd480;
        cyc();
        h_count = 10'd1; v_count = 10'd0;
        cyc();
      end
    endcase
  endtask

  task automatic compare_model(input int it);
    check($sformatf("rnd%0d_sel", it), {6'd0, pattern_sel}, 8'(m_sel));
    check($sformatf("rnd%0d_act", it), {7'd0, pattern_active}, 8'(m_act));
    check($sformatf("rnd%0d_tick", it), {7'd0, frame_tick}, 8'(m_tick));
    check($sformatf("rnd%0d_rdata", it), bus_if.rdata, 8'(m_rd));
  endtask

  initial begin
    vec_t tbl[$];
    tbl = '{
      '{1, 1, 0,    0, 0, 8'h3C}, '{1, 2, 0,    0, 0, 8'h0F}, '{1, 3, 0,    0, 0, 8'h00},
      '{0, 0, 8'h19, 0, 0, -1},   '{2, 0, 0,    3, 1, -1},    '{1, 3, 0,    3, 1, 8'h17},
      '{0, 1, 2,    3, 1, -1},    '{0, 2, 5,    3, 1, -1},    '{0, 0, 8'h03, 3, 1, -1},
      '{2, 0, 0,    0, 1, -1},    '{2, 0, 0,    0, 1, -1},    '{2, 0, 0,    2, 1, -1},
      '{2, 0, 0,    2, 1, -1},    '{2, 0, 0,    0, 1, -1},    '{2, 0, 0,    0, 1, -1},
      '{1, 3, 0,    0, 1, 8'h24}, '{0, 2, 6,    0, 1, -1},    '{0, 1, 1,    0, 1, -1},
      '{0, 0, 8'h05, 0, 1, -1},   '{2, 0, 0,    1, 1, -1},    '{2, 0, 0,    2, 1, -1},
      '{2, 0, 0,    2, 0, -1},    '{1, 3, 0,    2, 0, 8'h3A}, '{2, 0, 0,    2, 0, -1},
      '{2, 0, 0,    2, 0, -1},    '{2, 0, 0,    2, 0, -1},    '{1, 3, 0,    2, 0, 8'h3A},
      '{0, 1, 0,    2, 0, -1},    '{0, 0, 8'h03, 2, 0, -1},   '{2, 0, 0,    1, 1, -1},
      '{2, 0, 0,    2, 1, -1},    '{2, 0, 0,    1, 1, -1},    '{1, 0, 0,    1, 1, 8'h03},
      '{0, 0, 8'hFF, 1, 1, -1},   '{1, 0, 0,    1, 1, 8'h1F}, '{2, 0, 0,    3, 1, -1},
      '{0, 2, 8'hF6, 3, 1, -1},   '{1, 2, 0,    3, 1, 8'h06}, '{0, 3, 8'hAA, 3, 1, -1},
      '{1, 3, 0,    3, 1, 8'h17}
    };

    rst = 1'b1; h_count = 10'd1; v_count = 10'd0;
    bus_if.cs = 1'b0; bus_if.we = 1'b0; bus_if.addr = 2'd0; bus_if.wdata = 8'd0;
    model_reset();
    cyc(); cyc();
    check("reset_sel", {6'd0, pattern_sel}, 8'h00);
    check("reset_act", {7'd0, pattern_active}, 8'h00);
    check("reset_tick", {7'd0, frame_tick}, 8'h00);
    check("reset_rdata", bus_if.rdata, 8'h00);
    rst = 1'b0;
    cyc();

    foreach (tbl[i]) begin
      do_op(tbl[i].op, tbl[i].addr, tbl[i].data);
      check($sformatf("vec%0d_sel", i), {6'd0, pattern_sel}, 8'(tbl[i].esel));
      check($sformatf("vec%0d_act", i), {7'd0, pattern_active}, 8'(tbl[i].eact));
      if (tbl[i].erd >= 0) check($sformatf("vec%0d_rdata", i), bus_if.rdata, 8'(tbl[i].erd));
    end

    // CTRL write landing on the tick cycle: old config now, new config next tick.
    do_op(0, 0, 8'h11);
    h_count = 10'd0; v_count = 10'd480;
    cyc();
    check("same_cycle_tick", {7'd0, frame_tick}, 8'h01);
    h_count = 10'd1; v_count = 10'd0;
    bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.addr = 2'd0; bus_if.wdata = 8'h09;
    cyc();
    bus_if.cs = 1'b0; bus_if.we = 1'b0;
    check("same_cycle_old_sel", {6'd0, pattern_sel}, 8'h02);
    check("same_cycle_old_act", {7'd0, pattern_active}, 8'h01);
    do_op(2, 0, 0);
    check("same_cycle_new_sel", {6'd0, pattern_sel}, 8'h01);

    // Asynchronous reset between ticks while auto-cycling.
    do_op(0, 2, 8'h0F); do_op(0, 1, 1); do_op(0, 0, 8'h03);
    do_op(2, 0, 0); do_op(2, 0, 0); do_op(2, 0, 0);
    do_op(1, 3, 0);
    check("pre_rst_sel", {6'd0, pattern_sel}, 8'h02);
    check("pre_rst_rdata", bus_if.rdata, 8'h26);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_sel", {6'd0, pattern_sel}, 8'h00);
    check("async_rst_act", {7'd0, pattern_active}, 8'h00);
    check("async_rst_tick", {7'd0, frame_tick}, 8'h00);
    check("async_rst_rdata", bus_if.rdata, 8'h00);
    model_reset();
    cyc();
    rst = 1'b0;
    cyc();
    do_op(1, 2, 0);
    check("post_rst_mask", bus_if.rdata, 8'h0F);
    do_op(1, 3, 0);
    check("post_rst_status", bus_if.rdata, 8'h00);
    do_op(1, 1, 0);
    check("post_rst_dwell", bus_if.rdata, 8'h3C);

    // Random traffic against the model.
    for (int it = 0; it < 3000; it++) begin
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 5) == 0) begin
        h_count = 10'd0; v_count = 10'd480;
      end else begin
        h_count = 10'($urandom_range(0, 799));
        v_count = 10'($urandom_range(0, 524));
      end
      bus_if.cs    = 1'($urandom_range(0, 1));
      bus_if.we    = 1'($urandom_range(0, 1));
      bus_if.addr  = 2'($urandom_range(0, 3));
      bus_if.wdata = (bus_if.addr == 2'd1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      if (bus_if.we && bus_if.addr == 2'd0 && $urandom_range(0, 3) != 0) bus_if.cs = 1'b0;
      cyc();
      rst = 1'b0;
      compare_model(it);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
